// File: rtl/rvvi_pkg.sv
// Shared types and defaults for the RVVI trace-link blocks.
package rvvi_pkg;

    typedef enum logic [1:0] {
        RPL_IDLE   = 2'd0,
        RPL_REPLAY = 2'd1,
        RPL_WAIT   = 2'd2
    } rpl_state_t;

    localparam int TAGW_DEF = 16;

endpackage

// File: rtl/rvvi_tag_cam.sv
// Tag store for the replay list: per-slot sequence tags, Active flags and an
// Active-qualified lookup returning the lowest matching slot.
module rvvi_tag_cam
    import rvvi_pkg::*;
#(
    parameter int LOGDEPTH = 3,
    parameter int TAGW     = TAGW_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [LOGDEPTH-1:0]    wr_idx,
    input  logic [TAGW-1:0]        wr_tag,
    input  logic                   cmp_en,
    input  logic [TAGW-1:0]        cmp_tag,
    output logic [2**LOGDEPTH-1:0] active,
    output logic                   hit,
    output logic [LOGDEPTH-1:0]    hit_idx
);

    localparam int DEPTH = 2**LOGDEPTH;

    logic [TAGW-1:0]     tag_q [DEPTH];
    logic [DEPTH-1:0]    active_q;
    logic [DEPTH-1:0]    active_d;
    logic [DEPTH-1:0]    match_s;
    logic [LOGDEPTH-1:0] hit_idx_s;

    // Compare the incoming ack against every live slot.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = active_q[i] & (tag_q[i] == cmp_tag);
        end
    end

    // Priority encoder: lowest matching slot wins if tags repeat.
    always_comb begin
        hit_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                hit_idx_s = LOGDEPTH'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign hit     = cmp_en & (|match_s);
    assign hit_idx = hit_idx_s;
    assign active  = active_q;

    // Ack clears a slot; an insert to the same slot is applied last so it wins.
    always_comb begin
        active_d = active_q;
        if (hit) begin
            active_d[hit_idx_s] = 1'b0;
        end else begin
            active_d = active_d;
        end
        if (wr_en) begin
            active_d[wr_idx] = 1'b1;
        end else begin
            active_d = active_d;
        end
    end

    // Active flags and tag storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            if (wr_en) begin
                tag_q[wr_idx] <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/rvvi_replay_list.sv
// Retransmit buffer for the RVVI trace link: keeps sent packets until acked,
// retires them in order and replays the unacked window on gaps or timeouts.
module rvvi_replay_list
    import rvvi_pkg::*;
#(
    parameter int LOGDEPTH = 3,
    parameter int WIDTH    = 792,
    parameter int TAGW     = TAGW_DEF,
    parameter int TAGLSB   = 160,
    parameter int TIMEOUT  = 4096,
    parameter int MAXRETRY = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InsValid,
    input  logic [WIDTH-1:0] InsData,
    output logic             InsReady,
    input  logic             AckValid,
    input  logic [TAGW-1:0]  AckTag,
    output logic             AckMiss,
    output logic             RplValid,
    output logic [WIDTH-1:0] RplData,
    input  logic             RplReady,
    output logic             Full,
    output logic             Empty,
    output logic             Busy,
    output logic             Error
);

    localparam int DEPTH = 2**LOGDEPTH;
    localparam int PTRW  = LOGDEPTH + 1;
    localparam int TMRW  = $clog2(TIMEOUT) + 1;
    localparam int RTYW  = $clog2(MAXRETRY + 1) + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTRW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PTRW-1:0]     rpl_ptr_q, rpl_ptr_d, rpl_end_q, rpl_end_d;
    rpl_state_t          state_q, state_d;
    logic [RTYW-1:0]     retry_q, retry_d;
    logic [TMRW-1:0]     timer_q, timer_d;
    logic                hold_q, hold_d;
    logic                ack_miss_q, ack_miss_d;
    logic                error_q, error_d;

    logic [DEPTH-1:0]    active_s;
    logic                hit_s;
    logic [LOGDEPTH-1:0] hit_idx_s;
    logic [LOGDEPTH-1:0] head_idx_s, tail_idx_s, rpl_idx_s;
    logic                empty_s, full_s, ins_fire_s, retire_s;
    logic                timeout_s, ooo_ack_s, rpl_valid_s, enter_rpl_s;

    rvvi_tag_cam #(
        .LOGDEPTH (LOGDEPTH),
        .TAGW     (TAGW)
    ) u_cam (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ins_fire_s),
        .wr_idx  (head_idx_s),
        .wr_tag  (InsData[TAGLSB +: TAGW]),
        .cmp_en  (AckValid),
        .cmp_tag (AckTag),
        .active  (active_s),
        .hit     (hit_s),
        .hit_idx (hit_idx_s)
    );

    assign head_idx_s = head_q[LOGDEPTH-1:0];
    assign tail_idx_s = tail_q[LOGDEPTH-1:0];
    assign rpl_idx_s  = rpl_ptr_q[LOGDEPTH-1:0];
    assign empty_s    = (head_q == tail_q);
    assign full_s     = (head_idx_s == tail_idx_s) && (head_q[LOGDEPTH] != tail_q[LOGDEPTH]);
    assign ins_fire_s = InsValid & ~full_s;
    // A slot being offered on the replay port must not be freed under the arbiter.
    assign retire_s   = ~empty_s & ~active_s[tail_idx_s] & ~(hold_q & (rpl_ptr_q == tail_q));
    assign timeout_s  = ~empty_s & (timer_q == TMRW'(TIMEOUT - 1));
    assign ooo_ack_s  = hit_s & (hit_idx_s != tail_idx_s) & active_s[tail_idx_s];
    assign rpl_valid_s = (state_q == RPL_REPLAY) & (active_s[rpl_idx_s] | hold_q);

    // Queue pointers.
    always_comb begin
        head_d     = ins_fire_s ? head_q + PTRW'(1) : head_q;
        tail_d     = retire_s ? tail_q + PTRW'(1) : tail_q;
        ack_miss_d = AckValid & ~hit_s;
    end

    // Replay sequencer.
    always_comb begin
        state_d     = state_q;
        rpl_ptr_d   = rpl_ptr_q;
        rpl_end_d   = rpl_end_q;
        retry_d     = retry_q;
        hold_d      = hold_q;
        error_d     = error_q;
        enter_rpl_s = 1'b0;
        case (state_q)
            RPL_IDLE: begin
                if (ooo_ack_s | timeout_s) begin
                    state_d     = RPL_REPLAY;
                    rpl_ptr_d   = tail_q;
                    rpl_end_d   = head_q;
                    retry_d     = '0;
                    hold_d      = 1'b0;
                    enter_rpl_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            RPL_REPLAY: begin
                if (rpl_ptr_q == rpl_end_q) begin
                    state_d = RPL_WAIT;
                    hold_d  = 1'b0;
                end else if (rpl_valid_s) begin
                    if (RplReady) begin
                        rpl_ptr_d = rpl_ptr_q + PTRW'(1);
                        hold_d    = 1'b0;
                    end else begin
                        hold_d = 1'b1;
                    end
                end else begin
                    rpl_ptr_d = rpl_ptr_q + PTRW'(1);
                end
            end
            RPL_WAIT: begin
                if ((tail_q == rpl_end_q) | empty_s) begin
                    state_d = RPL_IDLE;
                end else if (timeout_s) begin
                    if (retry_q == RTYW'(MAXRETRY)) begin
                        error_d = 1'b1;
                        state_d = RPL_IDLE;
                    end else begin
                        retry_d     = retry_q + RTYW'(1);
                        rpl_ptr_d   = tail_q;
                        rpl_end_d   = head_q;
                        state_d     = RPL_REPLAY;
                        enter_rpl_s = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = RPL_IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    // Ack timer: idles during replay; a timeout also restarts it.
    always_comb begin
        if (retire_s | (ins_fire_s & empty_s) | enter_rpl_s | timeout_s) begin
            timer_d = '0;
        end else if (~empty_s & (state_q != RPL_REPLAY)) begin
            timer_d = timer_q + TMRW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            rpl_ptr_q  <= '0;
            rpl_end_q  <= '0;
            state_q    <= RPL_IDLE;
            retry_q    <= '0;
            timer_q    <= '0;
            hold_q     <= 1'b0;
            ack_miss_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            rpl_ptr_q  <= rpl_ptr_d;
            rpl_end_q  <= rpl_end_d;
            state_q    <= state_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            ack_miss_q <= ack_miss_d;
            error_q    <= error_d;
        end
    end

    // Packet payload storage.
    always_ff @(posedge clk) begin
        if (ins_fire_s) begin
            mem_q[head_idx_s] <= InsData;
        end
    end

    assign InsReady = ~full_s;
    assign Full     = full_s;
    assign Empty    = empty_s;
    assign AckMiss  = ack_miss_q;
    assign RplValid = rpl_valid_s;
    assign RplData  = mem_q[rpl_idx_s];
    assign Busy     = (state_q != RPL_IDLE);
    assign Error    = error_q;

endmodule
